// File: rtl/ram_dual_port_clr.sv
// Dual-port RAM: port A read/write with byte strobes, port B read-only, configurable
// read latency and collision mode, plus a post-reset clear sequence that zeroes every word.
module ram_dual_port_clr #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 64,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             resetn,
    output logic                             init_busy,
    input  logic                             a_en,
    input  logic [ADDR_WIDTH-1:0]            a_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_strobe,
    input  logic [DATA_WIDTH-1:0]            a_wdata,
    output logic [DATA_WIDTH-1:0]            a_rdata,
    output logic                             a_rvalid,
    input  logic                             b_en,
    input  logic [ADDR_WIDTH-1:0]            b_addr,
    output logic [DATA_WIDTH-1:0]            b_rdata,
    output logic                             b_rvalid
);
    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int LANES     = DATA_WIDTH / BYTE_WIDTH;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("ram_dual_port_clr: READ_LATENCY must be 1..4");
        end
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
            $error("ram_dual_port_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic [DATA_WIDTH-1:0]   mem [NUM_WORDS];

    logic                    a_acc, a_wr, b_acc;
    logic [DATA_WIDTH-1:0]   a_old, b_old, a_new, a_word, b_word;

    logic [DATA_WIDTH-1:0]   a_dat_p [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   b_dat_p [READ_LATENCY];
    logic [READ_LATENCY-1:0] a_vld_p, b_vld_p;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      strobe
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (strobe[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return res;
    endfunction

    // Clear FSM: walks clr_cnt_q through every address once, then opens the ports.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_READY;
            default:  state_d = ST_READY;
        endcase
    end

    assign init_busy = (state_q == ST_CLEAR);
    assign a_acc     = (state_q == ST_READY) && a_en;
    assign a_wr      = a_acc && (|a_strobe);
    assign b_acc     = (state_q == ST_READY) && b_en;

    assign a_old  = mem[a_addr];
    assign b_old  = mem[b_addr];
    assign a_new  = merge_lanes(a_old, a_wdata, a_strobe);
    assign a_word = (WRITE_MODE != 0) ? a_new : a_old;
    // Port B sees port A's same-edge write only in write-first mode.
    assign b_word = (WRITE_MODE != 0 && a_wr && a_addr == b_addr) ? a_new : b_old;

    always_ff @(posedge clk) begin
        if (resetn) begin
            if (state_q == ST_CLEAR) mem[clr_cnt_q] <= '0;
            else if (a_wr)           mem[a_addr]    <= a_new;
        end
    end

    // Stage 0 samples at the accept edge; later stages only advance behind a valid.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_vld_p <= '0;
            b_vld_p <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                a_dat_p[i] <= '0;
                b_dat_p[i] <= '0;
            end
        end else begin
            a_vld_p[0] <= a_acc;
            b_vld_p[0] <= b_acc;
            if (a_acc) a_dat_p[0] <= a_word;
            if (b_acc) b_dat_p[0] <= b_word;
            for (int i = 1; i < READ_LATENCY; i++) begin
                a_vld_p[i] <= a_vld_p[i-1];
                b_vld_p[i] <= b_vld_p[i-1];
                if (a_vld_p[i-1]) a_dat_p[i] <= a_dat_p[i-1];
                if (b_vld_p[i-1]) b_dat_p[i] <= b_dat_p[i-1];
            end
        end
    end

    assign a_rdata  = a_dat_p[READ_LATENCY-1];
    assign a_rvalid = a_vld_p[READ_LATENCY-1];
    assign b_rdata  = b_dat_p[READ_LATENCY-1];
    assign b_rvalid = b_vld_p[READ_LATENCY-1];

endmodule

// File: tb/tb_ram_dual_port_clr.sv
// Directed bench for ram_dual_port_clr: two instances share stimulus, one read-first with
// latency 1 and one write-first with latency 3, both with a 16-word array.
module tb_ram_dual_port_clr;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, a_en, b_en;
    logic [3:0]  a_addr, b_addr;
    logic [7:0]  a_strobe;
    logic [63:0] a_wdata;

    logic        busy0, a_rvalid0, b_rvalid0, busy1, a_rvalid1, b_rvalid1;
    logic [63:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1;

    ram_dual_port_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .BYTE_WIDTH(8), .READ_LATENCY(1),
                        .WRITE_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .resetn(resetn), .init_busy(busy0),
        .a_en(a_en), .a_addr(a_addr), .a_strobe(a_strobe), .a_wdata(a_wdata),
        .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata0), .b_rvalid(b_rvalid0));

    ram_dual_port_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .BYTE_WIDTH(8), .READ_LATENCY(3),
                        .WRITE_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .resetn(resetn), .init_busy(busy1),
        .a_en(a_en), .a_addr(a_addr), .a_strobe(a_strobe), .a_wdata(a_wdata),
        .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata1), .b_rvalid(b_rvalid1));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [63:0] ad0, ad1, bd0, bd1;
    int          al0, al1, bl0, bl1;

    // One request cycle, then watch both instances for the resulting pulses.
    task automatic access(input logic ae, input logic [3:0] aa, input logic [7:0] st,
                          input logic [63:0] wd, input logic be, input logic [3:0] ba);
        @(negedge clk);
        a_en = ae; a_addr = aa; a_strobe = st; a_wdata = wd; b_en = be; b_addr = ba;
        al0 = -1; al1 = -1; bl0 = -1; bl1 = -1;
        ad0 = '0; ad1 = '0; bd0 = '0; bd1 = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin a_en = 1'b0; b_en = 1'b0; a_strobe = '0; end
            if (a_rvalid0 && al0 < 0) begin al0 = k; ad0 = a_rdata0; end
            if (a_rvalid1 && al1 < 0) begin al1 = k; ad1 = a_rdata1; end
            if (b_rvalid0 && bl0 < 0) begin bl0 = k; bd0 = b_rdata0; end
            if (b_rvalid1 && bl1 < 0) begin bl1 = k; bd1 = b_rdata1; end
        end
    endtask

    // Call right after releasing resetn; returns the edge count at which init_busy fell.
    task automatic wait_clear(output int c0, output int c1);
        c0 = 0; c1 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (!busy0 && c0 == 0) c0 = k;
            if (!busy1 && c1 == 0) c1 = k;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, c1, stray, drop_k;
        int idx0[$], idx1[$];
        logic [63:0] q0[$], q1[$];

        resetn = 1'b0; a_en = 1'b0; b_en = 1'b0;
        a_addr = '0; b_addr = '0; a_strobe = '0; a_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {62'd0, busy0, busy1}, 64'd3);
        chk("reset_rvalid", {60'd0, a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1}, 64'd0);
        chk("reset_rdata0", a_rdata0 | b_rdata0, 64'd0);
        chk("reset_rdata1", a_rdata1 | b_rdata1, 64'd0);

        // T1: clear length and all-zero contents
        @(negedge clk); resetn = 1'b1;
        wait_clear(c0, c1);
        chk("clear_len0", 64'(c0), 64'd16);
        chk("clear_len1", 64'(c1), 64'd16);
        for (int i = 0; i < 16; i++) begin
            access(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'(i));
            chk("t1_b0", bd0, 64'd0);
            chk("t1_b1", bd1, 64'd0);
            chk("t1_lat0", 64'(bl0), 64'd0);
            chk("t1_lat1", 64'(bl1), 64'd2);
        end

        // T2: full-word write then read
        access(1'b1, 4'd5, 8'hFF, 64'h1122334455667788, 1'b0, 4'd0);
        chk("t2_a_rf", ad0, 64'd0);
        chk("t2_a_wf", ad1, 64'h1122334455667788);
        chk("t2_a_lat0", 64'(al0), 64'd0);
        chk("t2_a_lat1", 64'(al1), 64'd2);
        access(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd5);
        chk("t2_b0", bd0, 64'h1122334455667788);
        chk("t2_b1", bd1, 64'h1122334455667788);

        // T3: partial strobe
        access(1'b1, 4'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 4'd0);
        chk("t3_a_rf", ad0, 64'h1122334455667788);
        chk("t3_a_wf", ad1, 64'h11223344AAAAAAAA);
        access(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd5);
        chk("t3_b0", bd0, 64'h11223344AAAAAAAA);
        chk("t3_b1", bd1, 64'h11223344AAAAAAAA);

        // Zero strobe is a pure read
        access(1'b1, 4'd5, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b0, 4'd0);
        chk("pure_a0", ad0, 64'h11223344AAAAAAAA);
        chk("pure_a1", ad1, 64'h11223344AAAAAAAA);
        access(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd5);
        chk("pure_b0", bd0, 64'h11223344AAAAAAAA);
        chk("pure_b1", bd1, 64'h11223344AAAAAAAA);

        // T4: same-edge collision on addr 7
        access(1'b1, 4'd7, 8'hFF, 64'hFFFF, 1'b1, 4'd7);
        chk("t4_b_rf", bd0, 64'd0);
        chk("t4_b_wf", bd1, 64'hFFFF);
        chk("t4_a_rf", ad0, 64'd0);
        chk("t4_a_wf", ad1, 64'hFFFF);
        chk("t4_b_lat1", 64'(bl1), 64'd2);
        access(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd7);
        chk("t4_after0", bd0, 64'hFFFF);
        chk("t4_after1", bd1, 64'hFFFF);
        chk("hold_vld", {62'd0, b_rvalid0, b_rvalid1}, 64'd0);
        chk("hold_b0", b_rdata0, 64'hFFFF);
        chk("hold_b1", b_rdata1, 64'hFFFF);

        // Different-address write does not disturb a B read
        access(1'b1, 4'd8, 8'hFF, 64'h1234, 1'b1, 4'd7);
        chk("diff_b0", bd0, 64'hFFFF);
        chk("diff_b1", bd1, 64'hFFFF);

        // T5: back-to-back reads of addr 0..9
        for (int i = 0; i < 10; i++) access(1'b1, 4'(i), 8'hFF, 64'h100 + 64'(i), 1'b0, 4'd0);
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk); b_en = 1'b1; b_addr = 4'(i);
                end
                @(negedge clk); b_en = 1'b0;
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    @(posedge clk); #1;
                    if (b_rvalid0) begin idx0.push_back(k); q0.push_back(b_rdata0); end
                    if (b_rvalid1) begin idx1.push_back(k); q1.push_back(b_rdata1); end
                end
            end
        join
        chk("t5_cnt0", 64'(idx0.size()), 64'd10);
        chk("t5_cnt1", 64'(idx1.size()), 64'd10);
        if (idx1.size() == 10) begin
            chk("t5_first1", 64'(idx1[0]), 64'd2);
            chk("t5_span1", 64'(idx1[9] - idx1[0]), 64'd9);
            for (int i = 0; i < 10; i++) chk("t5_data1", q1[i], 64'h100 + 64'(i));
        end
        if (idx0.size() == 10) begin
            chk("t5_first0", 64'(idx0[0]), 64'd0);
            for (int i = 0; i < 10; i++) chk("t5_data0", q0[i], 64'h100 + 64'(i));
        end

        // T6a: reset in the middle of the clear sequence
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk); resetn = 1'b0;
        @(posedge clk); #1;
        chk("t6_busy_rst", {62'd0, busy0, busy1}, 64'd3);
        @(negedge clk); resetn = 1'b1;
        wait_clear(c0, c1);
        chk("t6_clear0", 64'(c0), 64'd16);
        chk("t6_clear1", 64'(c1), 64'd16);
        access(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd5);
        chk("t6_zero0", bd0, 64'd0);
        chk("t6_zero1", bd1, 64'd0);

        // T6b: reset while two reads are in flight
        access(1'b1, 4'd1, 8'hFF, 64'h55, 1'b0, 4'd0);
        @(negedge clk); b_en = 1'b1; b_addr = 4'd1;
        @(negedge clk); b_addr = 4'd2;
        @(negedge clk); b_en = 1'b0; resetn = 1'b0;
        stray = 0; drop_k = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                resetn = 1'b1;
                chk("t6_rdata_rst", b_rdata0 | b_rdata1 | a_rdata0 | a_rdata1, 64'd0);
            end
            if (a_rvalid0 || b_rvalid0 || a_rvalid1 || b_rvalid1) stray++;
            if (!busy1 && drop_k == 0) drop_k = k;
        end
        chk("t6_no_rvalid", 64'(stray), 64'd0);
        chk("t6_busy_len", 64'(drop_k), 64'd16);
        access(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd1);
        chk("t6_cleared0", bd0, 64'd0);
        chk("t6_cleared1", bd1, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
